// File: rtl/add_pkg.sv
// Shared definitions for the digit-serial 32-bit adder: datapath width,
// FSM state encoding and the digit-count helper.
package add_pkg;

  localparam int DATA_W = 32;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Number of clock cycles spent in RUN for a given digit width.
  function automatic int digits_of(input int digit_w);
    return DATA_W / digit_w;
  endfunction

endpackage

// File: rtl/add_32bit_serial_if.sv
// Start/done handshake and operand/result bus of the serial adder.
// ovf is only present when ADD_SERIAL_OVF_EN is defined.
interface add_32bit_serial_if;
  import add_pkg::*;

  logic              start;
  logic [DATA_W-1:0] Ra;
  logic [DATA_W-1:0] Rb;
  logic              cin;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] sum;
  logic              cout;
`ifdef ADD_SERIAL_OVF_EN
  logic              ovf;

  modport master (output start, Ra, Rb, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, Ra, Rb, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, Ra, Rb, cin, input busy, done, sum, cout);
  modport slave  (input start, Ra, Rb, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/add_digit.sv
// Combinational W-bit ripple-carry slice; the serial adder time-shares one
// instance across all digits of the operand.
module add_digit #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign co = c[W];

endmodule

// File: rtl/add_32bit_serial.sv
// Multi-cycle 32-bit adder, DIGIT_W bits per clock, start/done handshake.
// Optional signed-overflow output enabled by defining ADD_SERIAL_OVF_EN.
module add_32bit_serial
  import add_pkg::*;
#(
  parameter int DIGIT_W = 8
) (
  input  logic                clock,
  input  logic                clear,
  add_32bit_serial_if.slave   bus
);

  localparam int DIGITS = digits_of(DIGIT_W);
  localparam int KW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t              state;
  logic [KW-1:0]       k;
  logic [DATA_W-1:0]   ra_q, rb_q;
  logic [DATA_W-1:0]   psum, psum_nxt;
  logic                carry;
  logic [DATA_W-1:0]   sum_q;
  logic                cout_q;
  logic [DIGIT_W-1:0]  dig_a, dig_b, dig_s;
  logic                dig_co;
  logic                last;
  int                  idx;

  assign idx  = (DIGITS == 1) ? 0 : int'(k) * DIGIT_W;
  assign last = (k == KW'(DIGITS - 1));

  always_comb begin
    dig_a = ra_q[idx +: DIGIT_W];
    dig_b = rb_q[idx +: DIGIT_W];
  end

  add_digit #(.W(DIGIT_W)) u_digit (
    .a  (dig_a),
    .b  (dig_b),
    .ci (carry),
    .s  (dig_s),
    .co (dig_co)
  );

  // Partial sum with the current digit merged in, so the final digit can be
  // committed to sum on the same edge that produces it.
  always_comb begin
    psum_nxt                    = psum;
    psum_nxt[idx +: DIGIT_W]    = dig_s;
  end

`ifdef ADD_SERIAL_OVF_EN
  logic ovf_q;
`endif

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state  <= IDLE;
      k      <= '0;
      ra_q   <= '0;
      rb_q   <= '0;
      psum   <= '0;
      carry  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
`ifdef ADD_SERIAL_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          ra_q  <= bus.Ra;
          rb_q  <= bus.Rb;
          carry <= bus.cin;
          psum  <= '0;
          k     <= '0;
          state <= RUN;
        end
        RUN: begin
          psum  <= psum_nxt;
          carry <= dig_co;
          k     <= k + 1'b1;
          if (last) begin
            k      <= '0;
            sum_q  <= psum_nxt;
            cout_q <= dig_co;
`ifdef ADD_SERIAL_OVF_EN
            ovf_q  <= (ra_q[DATA_W-1] == rb_q[DATA_W-1]) &&
                      (psum_nxt[DATA_W-1] != ra_q[DATA_W-1]);
`endif
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef ADD_SERIAL_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_add_32bit_serial.sv
// Bench for add_32bit_serial: three digit widths (1, 8, 32) side by side,
// each checked every cycle against a timeline model of the add.
module tb_add_32bit_serial;

  logic        clk = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] ra, rb;
  logic        cin;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  localparam int NCFG = 3;

  logic [31:0] a_sum [NCFG], e_sum [NCFG];
  logic        a_busy[NCFG], e_busy[NCFG];
  logic        a_done[NCFG], e_done[NCFG];
  logic        a_cout[NCFG], e_cout[NCFG];
`ifdef ADD_SERIAL_OVF_EN
  logic        a_ovf [NCFG], e_ovf [NCFG];
`endif

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int DW = (g == 0) ? 1 : (g == 1) ? 8 : 32;
    localparam int DG = 32 / DW;

    add_32bit_serial_if bus ();
    assign bus.start = start;
    assign bus.Ra    = ra;
    assign bus.Rb    = rb;
    assign bus.cin   = cin;

    add_32bit_serial #(.DIGIT_W(DW)) dut (
      .clock (clk),
      .clear (clear),
      .bus   (bus.slave)
    );

    // phase = edges since acceptance: 1..DG busy, DG+1 done, 0 idle
    int          phase;
    logic [32:0] pend;
    logic [31:0] pa, pb;
    logic [31:0] m_sum;
    logic        m_cout, m_ovf;

    always @(posedge clk or negedge clear) begin
      if (!clear) begin
        phase <= 0; pend <= '0; pa <= '0; pb <= '0;
        m_sum <= '0; m_cout <= 1'b0; m_ovf <= 1'b0;
      end else if (phase == 0) begin
        if (start) begin
          pend  <= {1'b0, ra} + {1'b0, rb} + {32'd0, cin};
          pa    <= ra;
          pb    <= rb;
          phase <= 1;
        end
      end else if (phase == DG) begin
        {m_cout, m_sum} <= pend;
        m_ovf <= (pa[31] == pb[31]) && (pend[31] != pa[31]);
        phase <= DG + 1;
      end else if (phase == DG + 1) begin
        phase <= 0;
      end else begin
        phase <= phase + 1;
      end
    end

    assign a_sum[g]  = bus.sum;   assign e_sum[g]  = m_sum;
    assign a_busy[g] = bus.busy;  assign e_busy[g] = (phase >= 1) && (phase <= DG);
    assign a_done[g] = bus.done;  assign e_done[g] = (phase == DG + 1);
    assign a_cout[g] = bus.cout;  assign e_cout[g] = m_cout;
`ifdef ADD_SERIAL_OVF_EN
    assign a_ovf[g]  = bus.ovf;   assign e_ovf[g]  = m_ovf;
`endif
  end

  int dws [NCFG] = '{1, 8, 32};
  int lat [NCFG];
  int bcnt[NCFG];
  int dcnt[NCFG];

  task automatic chk(input string nm, input int dw, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dw=%0d actual=%h required=%h", nm, dw, act, exp);
    end
  endtask

  task automatic cmp_all();
    for (int g = 0; g < NCFG; g++) begin
      chk("busy", dws[g], 32'(a_busy[g]), 32'(e_busy[g]));
      chk("done", dws[g], 32'(a_done[g]), 32'(e_done[g]));
      chk("sum",  dws[g], a_sum[g], e_sum[g]);
      chk("cout", dws[g], 32'(a_cout[g]), 32'(e_cout[g]));
`ifdef ADD_SERIAL_OVF_EN
      chk("ovf",  dws[g], 32'(a_ovf[g]), 32'(e_ovf[g]));
`endif
    end
  endtask

  // Advance to the next falling edge and check every instance against the model.
  task automatic tick();
    @(negedge clk);
    cmp_all();
    for (int g = 0; g < NCFG; g++) if (a_done[g]) dcnt[g]++;
  endtask

  // One start pulse; records done latency and busy length per instance.
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic c);
    ra = a; rb = b; cin = c; start = 1'b1;
    for (int g = 0; g < NCFG; g++) begin lat[g] = -1; bcnt[g] = 0; end
    tick();
    start = 1'b0;
    for (int g = 0; g < NCFG; g++) if (a_busy[g]) bcnt[g]++;
    for (int t = 2; t <= 36; t++) begin
      tick();
      for (int g = 0; g < NCFG; g++) begin
        if (a_busy[g]) bcnt[g]++;
        if (a_done[g] && lat[g] < 0) lat[g] = t - 1;
      end
    end
  endtask

  task automatic chk_result(input string nm, input logic [31:0] s, input logic c);
    for (int g = 0; g < NCFG; g++) begin
      chk({nm, "_sum"},  dws[g], a_sum[g], s);
      chk({nm, "_cout"}, dws[g], 32'(a_cout[g]), 32'(c));
      chk({nm, "_model"}, dws[g], e_sum[g], s);
      chk({nm, "_lat"},  dws[g], lat[g], 32 / dws[g]);
      chk({nm, "_busy"}, dws[g], bcnt[g], 32 / dws[g]);
    end
  endtask

  initial begin
    clear = 1'b0; start = 1'b0; ra = '0; rb = '0; cin = 1'b0;
    for (int g = 0; g < NCFG; g++) dcnt[g] = 0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NCFG; g++) begin
      chk("rst_busy", dws[g], 32'(a_busy[g]), 32'd0);
      chk("rst_done", dws[g], 32'(a_done[g]), 32'd0);
      chk("rst_sum",  dws[g], a_sum[g], 32'd0);
      chk("rst_cout", dws[g], 32'(a_cout[g]), 32'd0);
`ifdef ADD_SERIAL_OVF_EN
      chk("rst_ovf",  dws[g], 32'(a_ovf[g]), 32'd0);
`endif
    end
    clear = 1'b1;
    tick();

    op(32'h0000_0024, 32'h0000_0001, 1'b0);
    chk_result("small", 32'h0000_0025, 1'b0);
    op(32'hFFFF_FFFF, 32'h0000_00FF, 1'b1);
    chk_result("wrap", 32'h0000_00FF, 1'b1);

`ifdef ADD_SERIAL_OVF_EN
    op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    chk_result("ovf1", 32'h8000_0000, 1'b0);
    for (int g = 0; g < NCFG; g++) chk("ovf1_flag", dws[g], 32'(a_ovf[g]), 32'd1);
    op(32'h0000_0001, 32'h0000_0001, 1'b0);
    for (int g = 0; g < NCFG; g++) chk("ovf0_flag", dws[g], 32'(a_ovf[g]), 32'd0);
`endif

    // start held high with operands changing every cycle
    for (int g = 0; g < NCFG; g++) dcnt[g] = 0;
    start = 1'b1;
    for (int t = 0; t < 120; t++) begin
      ra = $urandom; rb = $urandom; cin = 1'($urandom);
      tick();
    end
    start = 1'b0;
    chk("held_dones", 1,  dcnt[0], 3);
    chk("held_dones", 8,  dcnt[1], 20);
    chk("held_dones", 32, dcnt[2], 40);
    repeat (40) tick();

    // clear dropped in the second RUN cycle
    ra = 32'h1234_5678; rb = 32'h1111_1111; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #1 clear = 1'b0;
    #1;
    for (int g = 0; g < NCFG; g++) begin
      chk("clr_busy", dws[g], 32'(a_busy[g]), 32'd0);
      chk("clr_done", dws[g], 32'(a_done[g]), 32'd0);
      chk("clr_sum",  dws[g], a_sum[g], 32'd0);
      chk("clr_cout", dws[g], 32'(a_cout[g]), 32'd0);
    end
    tick();
    tick();
    clear = 1'b1;
    tick();
    op(32'h0000_0001, 32'h0000_0002, 1'b0);
    chk_result("after_clr", 32'h0000_0003, 1'b0);

    // random traffic with random start spacing
    for (int t = 0; t < 400; t++) begin
      ra    = $urandom;
      rb    = ($urandom_range(0, 3) == 0) ? ~ra : $urandom;
      cin   = 1'($urandom);
      start = ($urandom_range(0, 2) == 0);
      tick();
    end
    start = 1'b0;
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/add_32bit_serial.md
# add_32bit_serial

Multi-cycle 32-bit adder that processes DIGIT_W bits per clock and uses a start/done handshake. It is the addition counterpart to the datapath's combinational subtractor, with the same operand, carry-in, sum and carry-out semantics (sum = Ra + Rb + cin). It sits beside the ALU as a low-area adder for multi-cycle instructions, and the control unit sequences it.

## Interface
Parameters:
- DIGIT_W, default 8: bits added per clock. Legal values are 1, 2, 4, 8, 16 and 32, and DIGIT_W must divide 32.

Ports:
- clock, input, 1: rising-edge clock.
- clear, input, 1: reset. It is asynchronous and active-low.
- start, input, 1: request. It is sampled only in IDLE.
- Ra, input, 32: operand A. It is latched on an accepted start.
- Rb, input, 32: operand B. It is latched on an accepted start.
- cin, input, 1: carry-in. It is latched on an accepted start.
- busy, output, 1: high while in RUN.
- done, output, 1: one-cycle pulse when the result is valid.
- sum, output, 32: result. It is held stable until the next result is written.
- cout, output, 1: carry out of bit 31.

## Operation
- FSM states are IDLE, RUN and DONE. DIGITS = 32/DIGIT_W.
- IDLE:
  - start=1 at a rising edge latches Ra, Rb and cin, sets digit index k=0, and moves to RUN.
  - start=0 stays in IDLE.
- RUN:
  - Each edge adds Ra[k*DIGIT_W +: DIGIT_W] + Rb[same] + carry. The low DIGIT_W bits are written into an internal partial-sum register, and the carry register is updated.
  - The carry register holds the latched cin before digit 0.
  - After the edge that processes digit DIGITS-1, the FSM moves to DONE, loads sum from the partial-sum register (including the final digit), and loads cout with the final carry.
- DONE: lasts one cycle with done=1, then returns to IDLE unconditionally.
- start is ignored in RUN and in DONE. It is not queued, so the requester must re-assert it in IDLE.
- Changes to Ra, Rb or cin after acceptance have no effect on the operation in flight.
- Arithmetic is unsigned modulo 2^32. cout is the 33rd bit. Because addition is commutative, swapping Ra and Rb yields an identical sum and cout.
- Reset (clear=0, at any time, including mid-RUN):
  - state=IDLE, busy=0, done=0, sum=0, cout=0, k=0.
  - The internal partial-sum and carry registers go to 0.
  - Any operation in flight is discarded.

## Timing
- Reset values of all outputs: busy=0, done=0, sum=32'h0, cout=0, and ovf=0 when compiled in.
- Let edge E0 be the edge that samples start=1 in IDLE.
- busy is high from after E0 until after edge E(DIGITS).
- done is high for exactly one cycle, between edges E(DIGITS) and E(DIGITS+1).
- sum and cout update at edge E(DIGITS) and hold until the next result is written.
- Latency: done is visible DIGITS cycles after E0. With the default DIGIT_W=8 that is 4 cycles, and with DIGIT_W=32 it is 1 cycle.
- Minimum start-to-start spacing is DIGITS+2 edges.
- Outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- ADD_SERIAL_OVF_EN:
  - When defined, an extra output port ovf (output, 1) is present. It is the two's-complement signed overflow: (Ra[31]==Rb[31]) && (sum[31]!=Ra[31]). It updates at the same edge as sum, resets to 0, and holds with sum.
  - When undefined, the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package add_pkg holds:
  - localparam DATA_W = 32.
  - The state typedef (IDLE, RUN, DONE) and its encoding.
  - The DIGITS derivation helper.
- Sub-module add_digit is a combinational DIGIT_W-bit ripple-carry slice (a, b, ci → s, co), instantiated once and time-shared across digits.
- The top level holds the FSM, the digit counter, the operand registers, the partial-sum register and the output registers.

## Test plan
- Ra=32'h0000_0024, Rb=32'h0000_0001, cin=0, start pulse → sum=32'h0000_0025, cout=0, with done exactly 4 cycles after the accepting edge and busy high for 4 cycles.
- Ra=32'hFFFF_FFFF, Rb=32'h0000_00FF, cin=1 → sum=32'h0000_00FF, cout=1.
- ADD_SERIAL_OVF_EN defined, Ra=32'h7FFF_FFFF, Rb=32'h0000_0001, cin=0 → sum=32'h8000_0000, cout=0, ovf=1. Then Ra=Rb=32'h0000_0001 → ovf=0.
- start held high continuously, with Ra/Rb changed mid-RUN → exactly one result per DIGITS+2 edges, each from the operands present at its accepting edge, and no extra done pulses.
- Drive clear low during the second RUN cycle → busy, done, sum and cout go to 0 immediately. After release, start with Ra=32'h1, Rb=32'h2 → sum=32'h3.
- Repeat the first two scenarios with DIGIT_W=1 and DIGIT_W=32 → identical results, with latency 32 and 1 cycles respectively.
